// File: rtl/ycr1_wbb_sram_slave.sv
// Wishbone burst slave serving cyc/stb/bl/bry bursts from a single-port synchronous SRAM.
// Writes go straight through per beat; reads use a 2-entry skid buffer to sustain 1 beat/cycle.
module ycr1_wbb_sram_slave #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int BW     = 4,
  parameter int BL     = 10,
  parameter int MEM_AW = 9
) (
  input  logic              wbs_clk_i,
  input  logic              wbs_rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic [AW-1:0]     wbs_adr_i,
  input  logic              wbs_we_i,
  input  logic [DW-1:0]     wbs_dat_i,
  input  logic [BW-1:0]     wbs_sel_i,
  input  logic [BL-1:0]     wbs_bl_i,
  input  logic              wbs_bry_i,
  output logic [DW-1:0]     wbs_dat_o,
  output logic              wbs_ack_o,
  output logic              wbs_lack_o,
  output logic              wbs_err_o,
  output logic              sram_csb_o,
  output logic              sram_web_o,
  output logic [MEM_AW-1:0] sram_addr_o,
  output logic [BW-1:0]     sram_wmask_o,
  output logic [DW-1:0]     sram_din_o,
  input  logic [DW-1:0]     sram_dout_i
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t            state, state_nxt;
  logic [MEM_AW-1:0] addr_q;
  logic [BL-1:0]     rem_q;
  logic [BL-1:0]     issue_q;
  logic              err_q;
  logic              inflight_q;
  logic [DW-1:0]     skid0_q, skid1_q;
  logic [1:0]        skid_cnt_q;

  logic              accept, wr_beat, rd_pop, rd_push, issue, ack, last, rd_live;
  logic [2:0]        occ;
  logic              unused_adr;

  assign unused_adr = ^{wbs_adr_i[AW-1:MEM_AW+2], wbs_adr_i[1:0]};

  assign accept  = (state == IDLE) && wbs_cyc_i && wbs_stb_i;
  assign rd_live = (state == RD) && wbs_cyc_i;
  assign wr_beat = (state == WR) && wbs_cyc_i && wbs_stb_i && wbs_we_i && wbs_bry_i;
  assign rd_pop  = rd_live && (skid_cnt_q != 2'd0) && wbs_bry_i;
  assign rd_push = rd_live && inflight_q;
  assign ack     = wr_beat || rd_pop;
  assign last    = (rem_q == BL'(1));
  // Skid occupancy counts reads already in flight so the buffer can never overflow.
  assign occ     = {1'b0, skid_cnt_q} + {2'b00, inflight_q};
  assign issue   = rd_live && (issue_q != '0) && (occ < (3'd2 + {2'b00, rd_pop}));

  always_ff @(posedge wbs_clk_i or negedge wbs_rst_n) begin
    if (!wbs_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = wbs_we_i ? WR : RD;
      WR, RD:  if (!wbs_cyc_i || (ack && last)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wbs_ack_o    = ack;
    wbs_lack_o   = ack && last;
    wbs_err_o    = ack && err_q;
    wbs_dat_o    = skid0_q;
    sram_csb_o   = !(wr_beat || issue);
    sram_web_o   = !wr_beat;
    sram_addr_o  = (wr_beat || issue) ? addr_q : '0;
    sram_wmask_o = wr_beat ? wbs_sel_i : '0;
    sram_din_o   = wr_beat ? wbs_dat_i : '0;
  end

  always_ff @(posedge wbs_clk_i or negedge wbs_rst_n) begin
    if (!wbs_rst_n) begin
      addr_q     <= '0;
      rem_q      <= '0;
      issue_q    <= '0;
      err_q      <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (accept) begin
        addr_q  <= wbs_adr_i[MEM_AW+1:2];
        // A zero burst length is served as a single beat flagged with err.
        rem_q   <= (wbs_bl_i == '0) ? BL'(1) : wbs_bl_i;
        issue_q <= (wbs_bl_i == '0) ? BL'(1) : wbs_bl_i;
        err_q   <= (wbs_bl_i == '0);
      end else begin
        if (wr_beat || issue) addr_q <= addr_q + MEM_AW'(1);
        if (ack)              rem_q  <= rem_q - BL'(1);
        if (issue)            issue_q <= issue_q - BL'(1);
      end
    end
  end

  always_ff @(posedge wbs_clk_i or negedge wbs_rst_n) begin
    if (!wbs_rst_n) begin
      skid0_q    <= '0;
      skid1_q    <= '0;
      skid_cnt_q <= 2'd0;
    end else if (!rd_live) begin
      skid_cnt_q <= 2'd0;
    end else if (rd_push && rd_pop) begin
      if (skid_cnt_q == 2'd1) begin
        skid0_q <= sram_dout_i;
      end else begin
        skid0_q <= skid1_q;
        skid1_q <= sram_dout_i;
      end
    end else if (rd_pop) begin
      skid0_q    <= skid1_q;
      skid_cnt_q <= skid_cnt_q - 2'd1;
    end else if (rd_push) begin
      if (skid_cnt_q == 2'd0) skid0_q <= sram_dout_i;
      else                    skid1_q <= sram_dout_i;
      skid_cnt_q <= skid_cnt_q + 2'd1;
    end
  end

endmodule

// File: tb/tb_ycr1_wbb_sram_slave.sv
// Directed bench for ycr1_wbb_sram_slave with a behavioural 1-cycle-latency SRAM and
// a bench-side expected memory image.
module tb_ycr1_wbb_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we, bry;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic [9:0]  bl;
  logic [31:0] dat_o, din, sram_dout;
  logic        ack, lack, err, csb, web;
  logic [8:0]  saddr;
  logic [3:0]  wmask;

  logic [31:0] mem     [512];
  logic [31:0] exp_mem [512];
  logic        fill;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ycr1_wbb_sram_slave dut (
    .wbs_clk_i    (clk),
    .wbs_rst_n    (rst_n),
    .wbs_cyc_i    (cyc),
    .wbs_stb_i    (stb),
    .wbs_adr_i    (adr),
    .wbs_we_i     (we),
    .wbs_dat_i    (dat),
    .wbs_sel_i    (sel),
    .wbs_bl_i     (bl),
    .wbs_bry_i    (bry),
    .wbs_dat_o    (dat_o),
    .wbs_ack_o    (ack),
    .wbs_lack_o   (lack),
    .wbs_err_o    (err),
    .sram_csb_o   (csb),
    .sram_web_o   (web),
    .sram_addr_o  (saddr),
    .sram_wmask_o (wmask),
    .sram_din_o   (din),
    .sram_dout_i  (sram_dout)
  );

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'hC0DE_0000 + i;
    end else if (!csb) begin
      if (!web) begin
        for (int b = 0; b < 4; b++)
          if (wmask[b]) mem[saddr][8*b +: 8] <= din[8*b +: 8];
      end else begin
        sram_dout <= mem[saddr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_burst(input logic [31:0] a, input int nbl, input logic [31:0] d0,
                          input logic [3:0] s, input logic [15:0] pat);
    int beats, n, k, w, idx;
    logic [31:0] d;
    beats = (nbl == 0) ? 1 : nbl;
    n = 0; k = 0;
    w = int'(a[10:2]);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = a; bl = nbl[9:0]; sel = s; bry = 0; dat = d0;
    #1 chk("wr_accept_noack", ack, 0);
    while (n < beats && k < 40) begin
      k++;
      @(negedge clk);
      bry = (k <= 16) ? pat[k-1] : 1'b1;
      d = d0 + n * 32'h0101_0101;
      dat = d;
      #1;
      chk("wr_ack_vs_bry", ack, bry);
      if (ack) begin
        idx = (w + n) % 512;
        chk("wr_addr", saddr, idx);
        chk("wr_csb_web", {csb, web}, 2'b00);
        chk("wr_wmask", wmask, s);
        chk("wr_din", din, d);
        chk("wr_lack", lack, (n == beats - 1));
        chk("wr_err", err, (nbl == 0));
        for (int b = 0; b < 4; b++)
          if (s[b]) exp_mem[idx][8*b +: 8] = d[8*b +: 8];
        n++;
      end
    end
    chk("wr_beats", n, beats);
    @(negedge clk);
    cyc = 0; stb = 0; we = 0; bry = 0;
    #1 chk("wr_idle_csb", csb, 1);
    for (int i = 0; i < beats; i++)
      chk("wr_mem", mem[(w + i) % 512], exp_mem[(w + i) % 512]);
  endtask

  task automatic rd_burst(input logic [31:0] a, input int nbl, input int lo_s, input int lo_e,
                          input int abort_n, input int first_exp);
    int beats, n, k, w, issued, maxo, first, last_k, ab;
    beats = (nbl == 0) ? 1 : nbl;
    n = 0; k = 0; issued = 0; maxo = 0; first = -1; last_k = -1; ab = 0;
    w = int'(a[10:2]);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = a; bl = nbl[9:0]; sel = 4'hF; bry = 0; dat = 0;
    #1 chk("rd_accept_noack", ack, 0);
    while (n < beats && k < 40) begin
      k++;
      @(negedge clk);
      if (abort_n > 0 && n == abort_n) begin cyc = 0; stb = 0; end
      bry = !(k >= lo_s && k <= lo_e);
      #1;
      if (!cyc) begin
        chk("abort_no_ack", ack, 0);
        chk("abort_csb", csb, 1);
        ab++;
        if (ab == 5) break;
      end else begin
        if (!csb && web) issued++;
        if (ack) begin
          chk("rd_ack_needs_bry", bry, 1);
          chk("rd_data", dat_o, exp_mem[(w + n) % 512]);
          chk("rd_lack", lack, (n == beats - 1));
          chk("rd_err", err, (nbl == 0));
          if (first < 0) first = k;
          last_k = k;
          n++;
        end
        if (issued - n > maxo) maxo = issued - n;
      end
    end
    if (abort_n > 0) begin
      chk("abort_acks", n, abort_n);
    end else begin
      chk("rd_beats", n, beats);
      chk("rd_issued", issued, beats);
    end
    chk("rd_outstanding_le2", (maxo <= 2), 1);
    if (first_exp > 0) begin
      chk("rd_first_ack_cycle", first, first_exp);
      chk("rd_last_ack_cycle", last_k, first_exp + beats - 1);
    end
    @(negedge clk);
    cyc = 0; stb = 0; bry = 0;
  endtask

  initial begin
    rst_n = 0; fill = 1;
    cyc = 0; stb = 0; we = 0; bry = 0; adr = 0; dat = 0; sel = 0; bl = 0;
    for (int i = 0; i < 512; i++) exp_mem[i] = 32'hC0DE_0000 + i;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ack", {ack, lack, err}, 3'b000);
    chk("rst_csb_web", {csb, web}, 2'b11);
    chk("rst_addr", saddr, 0);
    chk("rst_wmask_din", {wmask, din}, 0);
    chk("rst_dat_o", dat_o, 0);
    @(negedge clk);
    rst_n = 1; fill = 0;

    wr_burst(32'h10, 1, 32'hA5A5_1234, 4'hF, 16'hFFFF);
    wr_burst(32'h0, 4, 32'h1000_0000, 4'hF, 16'h002D);
    wr_burst(32'h14, 1, 32'h1122_3344, 4'h6, 16'hFFFF);
    rd_burst(32'h20, 8, 0, 0, 0, 3);
    rd_burst(32'h200, 6, 5, 8, 0, 0);
    rd_burst(32'h0, 5, 4, 6, 0, 0);
    rd_burst(32'hFFFF_F7F8, 3, 0, 0, 0, 3);
    wr_burst(32'h40, 0, 32'hDEAD_BEEF, 4'hF, 16'hFFFF);
    rd_burst(32'h40, 0, 0, 0, 0, 3);
    rd_burst(32'h80, 8, 0, 0, 2, 0);
    rd_burst(32'h100, 2, 0, 0, 0, 3);

    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h0; bl = 10'd4; bry = 1;
    @(negedge clk);
    #1 chk("rst_mid_issue", csb, 0);
    rst_n = 0;
    #1;
    chk("rst_mid_csb", csb, 1);
    chk("rst_mid_ack", ack, 0);
    cyc = 0; stb = 0; bry = 0;
    @(negedge clk);
    rst_n = 1;
    rd_burst(32'h8, 2, 0, 0, 0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
